// File: rtl/chnl_tx_driver_256.sv
// chnl_tx_driver_256
//   User-side transmitter for a 256-bit RIFFA CHNL_TX channel. Takes one
//   descriptor (length in words, offset, last) and a show-ahead source stream.
//   It drives the full channel write handshake. Beat counting, the 2-entry
//   output buffer and masking of the final partial beat are handled here.
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   REQ/REQ_READY            descriptor handshake (accepted when both high)
//   REQ_LEN/REQ_OFF/REQ_LAST descriptor fields, sampled only on accept
//   SRC_DATA/SRC_VALID       show-ahead source beat, word 0 in bits [31:0]
//   SRC_REN                  pops the current source beat
//   DONE/DONE_LEN            completion pulse and words sent (held)
//   CHNL_TX/CHNL_TX_ACK      channel write request / acceptance
//   CHNL_TX_LAST/LEN/OFF     registered descriptor seen by the channel
//   CHNL_TX_DATA/_VALID/_REN output beat; a beat moves when VALID && REN
//
// Handshake rules: every valid/ready pair transfers on the rising CLK edge
// where both are high. Valid never depends combinationally on its ready.
// SRC_REN is a pop strobe qualified by SRC_VALID, and the same rule applies.
module chnl_tx_driver_256 #(
  parameter int C_DATA_WIDTH     = 256,
  parameter int C_WORDS_PER_BEAT = C_DATA_WIDTH / 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ,
  output logic                    REQ_READY,
  input  logic [31:0]             REQ_LEN,
  input  logic [30:0]             REQ_OFF,
  input  logic                    REQ_LAST,
  input  logic [C_DATA_WIDTH-1:0] SRC_DATA,
  input  logic                    SRC_VALID,
  output logic                    SRC_REN,
  output logic                    DONE,
  output logic [31:0]             DONE_LEN,
  output logic                    CHNL_TX,
  input  logic                    CHNL_TX_ACK,
  output logic                    CHNL_TX_LAST,
  output logic [31:0]             CHNL_TX_LEN,
  output logic [30:0]             CHNL_TX_OFF,
  output logic [C_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                    CHNL_TX_DATA_VALID,
  input  logic                    CHNL_TX_DATA_REN
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DATA     = 2'd2
  } state_t;

  state_t                  state;
  logic [29:0]             beats;
  logic [29:0]             fetched;
  logic [29:0]             sent;
  logic [2:0]              rem;
  logic [1:0]              occ;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [C_DATA_WIDTH-1:0] buf_mem [2];
  logic [C_DATA_WIDTH-1:0] push_data;
  logic [29:0]             req_beats;
  logic                    xfer;

  // Ceiling of LEN/8 without overflow: LEN=0xFFFFFFFF gives 0x20000000.
  assign req_beats = {1'b0, REQ_LEN[31:3]} + {29'd0, |REQ_LEN[2:0]};

  // Fetch is gated only by registered state, so nothing in the channel's
  // REN path reaches SRC_REN combinationally.
  assign SRC_REN            = (state == DATA) && SRC_VALID &&
                              (fetched != beats) && (occ != 2'd2);
  assign CHNL_TX_DATA_VALID = (occ != 2'd0);
  assign CHNL_TX_DATA       = buf_mem[rd_ptr];
  assign xfer               = CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN;

  // The final beat of a transaction whose length is not a multiple of 8
  // words has its upper words zeroed as it enters the buffer.
  always_comb begin
    push_data = SRC_DATA;
    if ((fetched == beats - 30'd1) && (rem != 3'd0)) begin
      for (int w = 0; w < C_WORDS_PER_BEAT; w++) begin
        if (w >= int'(rem)) push_data[w*32 +: 32] = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      REQ_READY    <= 1'b0;
      CHNL_TX      <= 1'b0;
      CHNL_TX_LEN  <= '0;
      CHNL_TX_OFF  <= '0;
      CHNL_TX_LAST <= 1'b0;
      DONE         <= 1'b0;
      DONE_LEN     <= '0;
      beats        <= '0;
      rem          <= '0;
      fetched      <= '0;
      sent         <= '0;
      occ          <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      for (int i = 0; i < 2; i++) buf_mem[i] <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          REQ_READY <= 1'b1;
          if (REQ && REQ_READY) begin
            CHNL_TX_LEN  <= REQ_LEN;
            CHNL_TX_OFF  <= REQ_OFF;
            CHNL_TX_LAST <= REQ_LAST;
            beats        <= req_beats;
            rem          <= REQ_LEN[2:0];
            fetched      <= '0;
            sent         <= '0;
            occ          <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            CHNL_TX      <= 1'b1;
            REQ_READY    <= 1'b0;
            state        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (CHNL_TX_ACK) begin
            if (beats == 30'd0) begin
              // Zero-length transaction completes on the acknowledge.
              CHNL_TX   <= 1'b0;
              DONE      <= 1'b1;
              DONE_LEN  <= CHNL_TX_LEN;
              REQ_READY <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (SRC_REN) begin
            buf_mem[wr_ptr] <= push_data;
            wr_ptr          <= ~wr_ptr;
            fetched         <= fetched + 30'd1;
          end
          if (xfer) begin
            rd_ptr <= ~rd_ptr;
            sent   <= sent + 30'd1;
          end
          occ <= occ + {1'b0, SRC_REN} - {1'b0, xfer};
          if (xfer && (sent + 30'd1 == beats)) begin
            CHNL_TX   <= 1'b0;
            DONE      <= 1'b1;
            DONE_LEN  <= CHNL_TX_LEN;
            REQ_READY <= 1'b1;
            occ       <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chnl_tx_driver_256.sv
module tb_chnl_tx_driver_256;

  // ---------------- clock / reset ----------------
  logic         CLK = 1'b0;
  logic         RST;
  logic         REQ;
  logic         REQ_READY;
  logic [31:0]  REQ_LEN;
  logic [30:0]  REQ_OFF;
  logic         REQ_LAST;
  logic [255:0] SRC_DATA;
  logic         SRC_VALID;
  logic         SRC_REN;
  logic         DONE;
  logic [31:0]  DONE_LEN;
  logic         CHNL_TX;
  logic         CHNL_TX_ACK;
  logic         CHNL_TX_LAST;
  logic [31:0]  CHNL_TX_LEN;
  logic [30:0]  CHNL_TX_OFF;
  logic [255:0] CHNL_TX_DATA;
  logic         CHNL_TX_DATA_VALID;
  logic         CHNL_TX_DATA_REN;

  always #5 CLK = ~CLK;

  chnl_tx_driver_256 dut (
    .CLK(CLK), .RST(RST),
    .REQ(REQ), .REQ_READY(REQ_READY),
    .REQ_LEN(REQ_LEN), .REQ_OFF(REQ_OFF), .REQ_LAST(REQ_LAST),
    .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID), .SRC_REN(SRC_REN),
    .DONE(DONE), .DONE_LEN(DONE_LEN),
    .CHNL_TX(CHNL_TX), .CHNL_TX_ACK(CHNL_TX_ACK),
    .CHNL_TX_LAST(CHNL_TX_LAST), .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(CHNL_TX_OFF),
    .CHNL_TX_DATA(CHNL_TX_DATA), .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
    .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN)
  );

  // ---------------- scoreboard state ----------------
  int           checks = 0;
  int           errors = 0;
  logic [255:0] exp_q[$];
  logic [31:0]  m_len;
  int           m_beats, m_fetched, pops, xfers, m_occ, occ_max;
  int           tx_high_cnt, done_cnt, cyc, ack_wait, ack_delay;
  int           src_mode, ren_mode, data_mode;
  bit           popped, done_seen, acked, len_bad, ready_bad;
  logic [255:0] last_beat;
  logic [255:0] tail_exp;
  int           rst_done, dc;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] gen_beat();
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[w*32 +: 32] = (data_mode != 0) ? 32'hFFFF_FFFF : $urandom;
    return b;
  endfunction

  // Mid-cycle monitor: everything seen here takes effect on the next edge.
  task automatic monitor();
    logic [255:0] e;
    bit xf;
    popped = 0;
    xf = 0;
    if (CHNL_TX) begin
      tx_high_cnt++;
      if (CHNL_TX_LEN !== m_len) len_bad = 1;
      if (REQ_READY) ready_bad = 1;
    end
    if (SRC_REN) begin
      e = SRC_DATA;
      if (m_fetched == m_beats - 1 && m_len[2:0] != 3'd0)
        for (int w = 0; w < 8; w++) if (w >= int'(m_len[2:0])) e[w*32 +: 32] = '0;
      exp_q.push_back(e);
      m_fetched++;
      pops++;
      popped = 1;
    end
    if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) begin
      xf = 1;
      xfers++;
      last_beat = CHNL_TX_DATA;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL beat_extra got=beat%0d exp=none_pending", xfers);
      end
      if (exp_q.size() != 0) chk("beat_data", CHNL_TX_DATA, exp_q.pop_front());
    end
    if (DONE) begin
      done_cnt++;
      done_seen = 1;
      chk("done_len", DONE_LEN, m_len);
      chk("done_tx_low", CHNL_TX, 1'b0);
      chk("done_valid_low", CHNL_TX_DATA_VALID, 1'b0);
      chk("done_req_ready", REQ_READY, 1'b1);
    end
    m_occ = m_occ + int'(popped) - int'(xf);
    if (m_occ > occ_max) occ_max = m_occ;
  endtask

  // Post-edge driver: source advance, flow-control patterns, ACK.
  task automatic drive();
    cyc++;
    if (popped) SRC_DATA = gen_beat();
    SRC_VALID        = (src_mode == 0) ? 1'b1 : (cyc % 3 != 0);
    CHNL_TX_DATA_REN = (ren_mode == 0) ? 1'b1 : (cyc % 2 == 0);
    CHNL_TX_ACK      = 1'b0;
    if (CHNL_TX && !acked) begin
      if (ack_wait >= ack_delay) begin
        CHNL_TX_ACK = 1'b1;
        acked = 1;
      end else begin
        ack_wait++;
      end
    end
  endtask

  task automatic run_txn(input logic [31:0] len, input logic [30:0] off, input logic last,
                         input int ackd, input bit pre, input bit chain,
                         input logic [31:0] nlen, input logic [30:0] noff, input logic nlast,
                         input int abort_at);
    int n;
    m_len = len; m_beats = int'((longint'(len) + 7) / 8);
    m_fetched = 0; pops = 0; xfers = 0; m_occ = 0; occ_max = 0; tx_high_cnt = 0;
    done_seen = 0; acked = 0; ack_wait = 0; ack_delay = ackd; len_bad = 0; ready_bad = 0;
    exp_q.delete();
    if (!pre) begin
      REQ = 1'b1; REQ_LEN = len; REQ_OFF = off; REQ_LAST = last;
      @(negedge CLK);
      chk("req_ready", REQ_READY, 1'b1);
      monitor();
      @(posedge CLK); #1;
    end
    REQ = chain;
    if (chain) begin
      REQ_LEN = nlen; REQ_OFF = noff; REQ_LAST = nlast;
    end
    chk("tx_rise", CHNL_TX, 1'b1);
    chk("tx_len", CHNL_TX_LEN, len);
    chk("tx_off", CHNL_TX_OFF, off);
    chk("tx_last", CHNL_TX_LAST, last);
    if (!pre) drive();
    n = 0;
    while (!done_seen && n < 3000) begin
      @(negedge CLK);
      monitor();
      @(posedge CLK); #1;
      drive();
      n++;
      if (abort_at != 0 && xfers == abort_at) break;
    end
    if (abort_at == 0) begin
      chk("done_seen", done_seen, 1'b1);
      chk("pop_count", pops, m_beats);
      chk("xfer_count", xfers, m_beats);
      chk("queue_empty", exp_q.size(), 0);
      chk("occ_le_2", occ_max <= 2, 1'b1);
      chk("len_held", len_bad, 1'b0);
      chk("ready_low_busy", ready_bad, 1'b0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RST = 1'b1; REQ = 1'b0; REQ_LEN = '0; REQ_OFF = '0; REQ_LAST = 1'b0;
    SRC_VALID = 1'b1; CHNL_TX_ACK = 1'b0; CHNL_TX_DATA_REN = 1'b1;
    src_mode = 0; ren_mode = 0; data_mode = 0; cyc = 0; done_cnt = 0; popped = 0;
    SRC_DATA = gen_beat();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tx", CHNL_TX, 1'b0);
    chk("rst_valid", CHNL_TX_DATA_VALID, 1'b0);
    chk("rst_len", CHNL_TX_LEN, 32'd0);
    chk("rst_off", CHNL_TX_OFF, 31'd0);
    chk("rst_last", CHNL_TX_LAST, 1'b0);
    chk("rst_data", CHNL_TX_DATA, 256'd0);
    chk("rst_src_ren", SRC_REN, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_done_len", DONE_LEN, 32'd0);
    chk("rst_req_ready", REQ_READY, 1'b0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("ready_after_rst", REQ_READY, 1'b1);

    // Full-beat transaction.
    run_txn(32'd16, 31'd0, 1'b1, 0, 0, 0, 32'd0, 31'd0, 1'b0, 0);

    // Partial final beat, all-ones source.
    data_mode = 1;
    SRC_DATA = gen_beat();
    run_txn(32'd13, 31'h100, 1'b0, 1, 0, 0, 32'd0, 31'd0, 1'b0, 0);
    tail_exp = '0;
    for (int w = 0; w < 5; w++) tail_exp[w*32 +: 32] = 32'hFFFF_FFFF;
    chk("t2_tail_mask", last_beat, tail_exp);
    data_mode = 0;
    SRC_DATA = gen_beat();

    // Zero length: request held until ACK, no fetch.
    run_txn(32'd0, 31'd4, 1'b1, 3, 0, 0, 32'd0, 31'd0, 1'b0, 0);
    chk("t3_tx_high_cycles", tx_high_cnt, 4);

    // Backpressure and source stalls.
    src_mode = 1; ren_mode = 1;
    run_txn(32'd64, 31'd9, 1'b0, 2, 0, 0, 32'd0, 31'd0, 1'b0, 0);
    src_mode = 0; ren_mode = 0;

    // Second request held during the first, taken in the DONE cycle.
    run_txn(32'd24, 31'd7, 1'b0, 2, 0, 1, 32'd16, 31'd5, 1'b0, 0);
    run_txn(32'd16, 31'd5, 1'b0, 1, 1, 0, 32'd0, 31'd0, 1'b0, 0);

    // Reset in the middle of the data phase.
    run_txn(32'd64, 31'd0, 1'b1, 0, 0, 0, 32'd0, 31'd0, 1'b0, 3);
    dc = done_cnt;
    chk("abort_after_3", xfers, 3);
    RST = 1'b1;
    #1;
    chk("abort_tx", CHNL_TX, 1'b0);
    chk("abort_valid", CHNL_TX_DATA_VALID, 1'b0);
    chk("abort_src_ren", SRC_REN, 1'b0);
    chk("abort_req_ready", REQ_READY, 1'b0);
    rst_done = 0;
    repeat (3) begin
      @(negedge CLK);
      if (DONE) rst_done++;
    end
    chk("abort_no_done", rst_done, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    popped = 0;
    @(posedge CLK); #1;
    chk("abort_done_cnt", done_cnt, dc);
    run_txn(32'd8, 31'd0, 1'b1, 1, 0, 0, 32'd0, 31'd0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
